tag_fifo_sched: RTL
===================

Name: tag_fifo_sched

Overview:
- Shares the tag FIFO between NUM_REQ tag-extraction lanes of the FIX parser on the write side.
- Sequences the FIFO read side for a single tag consumer.
- Drives the FIFO's wr_cs/wr_en/data and rd_cs/rd_en strobes.
- Keeps a shadow occupancy count, so it never writes when full or reads when empty, independent of the FIFO's registered status.

Parameters:
- NUM_REQ, 4, number of write requesters (≥2).
- DATA_WIDTH, 32, tag word width; matches the tag FIFO.
- ADDR_WIDTH, 8, tag FIFO address width. Usable capacity CAP = 2**ADDR_WIDTH − 1 = 255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_i  in  NUM_REQ  per-lane write request; held until granted.
- req_data_i  in  NUM_REQ*DATA_WIDTH  lane k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
- gnt_o  out  NUM_REQ  one-hot, combinational; lane's word accepted this cycle.
- rd_req_i  in  1  consumer wants one tag word.
- rd_gnt_o  out  1  combinational; read accepted this cycle.
- rd_valid_o  out  1  data_o of FIFO valid (two cycles after rd_gnt_o).
- fifo_wr_cs_o, fifo_wr_en_o  out  1 each  registered write strobes.
- fifo_data_o  out  DATA_WIDTH  registered write data.
- fifo_rd_cs_o, fifo_rd_en_o  out  1 each  registered read strobes.
- occupancy_o  out  ADDR_WIDTH  shadow count.
- full_o, empty_o  out  1 each  occupancy_o == CAP, occupancy_o == 0.

Behaviour:
- Reset, asynchronous:
  - All registered outputs 0; occupancy 0.
  - RR pointer selects lane 0 first; rd_valid pipeline cleared.
  - After reset: empty_o=1, full_o=0, gnt_o=0.
- Write arbitration, each cycle:
  - Write accepted iff any req_i and occupancy < CAP.
  - Winner is the first requesting lane at or after ptr, scanning upward with modulo wrap. gnt_o is one-hot for the winner.
  - On grant: ptr ← winner+1 (mod NUM_REQ); winner's data registered.
  - Next cycle: fifo_wr_cs_o = fifo_wr_en_o = 1 with that data, for exactly one cycle per grant. Back-to-back grants give continuous strobes.
  - No grant when occupancy == CAP. Ptr holds while there is no grant.
- Read sequencing:
  - rd_gnt_o = rd_req_i && occupancy > 0.
  - Next cycle: fifo_rd_cs_o = fifo_rd_en_o = 1 for one cycle.
  - rd_valid_o pulses the cycle after that, when the FIFO's registered data_o is valid. Read latency is 2 cycles from grant.
  - Back-to-back reads are allowed.
- Occupancy:
  - +1 on write grant, −1 on read grant, unchanged when both or neither occur.
  - Updates on the grant edge, not the strobe edge, so there is no in-flight over/underflow.
- Boundaries:
  - At CAP with simultaneous read+write request: read is granted; write is not granted that cycle (grant uses pre-update occupancy). Next cycle occupancy=CAP−1 and the write wins.
  - At 0 with simultaneous read+write: write granted, read refused.
  - Occupancy never wraps. Reaching CAP+1 or going below 0 is an assertion failure.
  - Lanes drop req_i only after gnt_o. Requests dropped without a grant are legal and simply not served.
- Fairness: every continuously requesting lane is granted within NUM_REQ grant cycles.
- Reset mid-operation: pending strobes and rd_valid pipeline cleared immediately. Occupancy is zeroed, and the FIFO must be reset on the same rst.

Decomposition:
- Package tag_fifo_pkg holds the TAG_DW and TAG_AW defaults, CAP, and function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module, rr_arbiter: parameterised NUM_REQ round-robin arbiter with req/gnt/advance ports and an internal pointer. The scheduler instantiates it for the write side.

Test Plan:
1. Reset, then lane 2 only: req_i=4'b0100, data 0xA5A5_0002 → gnt_o=0100 in the same cycle. fifo_wr_en_o=1, fifo_data_o=0xA5A5_0002 next cycle. occupancy_o=1.
2. All four lanes held requesting for 8 cycles → gnt_o sequence 0001,0010,0100,1000,0001,… occupancy_o=8.
3. Fill to 255 with lane 0 always requesting → gnt_o=0 once occupancy_o=255, full_o=1, no further fifo_wr_en_o.
4. At 255, rd_req_i=1 and lane 1 requesting → cycle 0: rd_gnt_o=1, gnt_o=0. Cycle 1: gnt_o=0010, occupancy_o stays 254 then 255. rd_valid_o at cycle 2.
5. Empty with rd_req_i=1 and lane 3 requesting → rd_gnt_o=0, gnt_o=1000. Next cycle rd_gnt_o=1. rd_valid_o two cycles later, carrying lane 3's data.
6. Assert rst mid-stream with occupancy 17 and a strobe pending → all strobes and rd_valid_o drop asynchronously, occupancy_o=0. First grant after release goes to lane 0 when all lanes request.

Source files
------------

// File: rtl/tag_fifo_pkg.sv
// tag_fifo_pkg: shared defaults and round-robin pick helper for the tag FIFO scheduler.
//   TAG_DW/TAG_AW : default tag word and FIFO address widths
//   CAP           : usable FIFO capacity for the default address width
//   rr_pick       : one-hot grant for the first request at or after ptr (wrapping mod n)
package tag_fifo_pkg;
    localparam int TAG_DW  = 32;
    localparam int TAG_AW  = 8;
    localparam int CAP     = 2**TAG_AW - 1;
    localparam int MAX_REQ = 32;
    localparam int IW      = $clog2(MAX_REQ);

    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        logic [MAX_REQ-1:0] g;
        logic [IW-1:0]      idx;
        g = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = IW'((ptr + i) % n);
            if (i < n && g == '0 && req[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal priority pointer.
//   req_i     : per-lane requests
//   advance_i : grant is taken this cycle; pointer moves past the winner
//   gnt_o     : one-hot winner (combinational), zero when nothing requests
module rr_arbiter
    import tag_fifo_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_q, ptr_d, win;

    always_comb begin
        gnt_o = NUM_REQ'(rr_pick(MAX_REQ'(req_i), 32'(ptr_q), NUM_REQ));
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) if (gnt_o[i]) win = PW'(i);
        ptr_d = !advance_i ? ptr_q : (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/tag_fifo_sched.sv
// tag_fifo_sched: shares the tag FIFO write port among NUM_REQ lanes and sequences reads.
//   req_i/req_data_i/gnt_o       : lane write requests, packed lane data, one-hot grant
//   rd_req_i/rd_gnt_o/rd_valid_o : consumer read request, grant, FIFO data_o valid
//   fifo_wr_cs_o/fifo_wr_en_o/fifo_data_o, fifo_rd_cs_o/fifo_rd_en_o : registered FIFO strobes
//   occupancy_o/full_o/empty_o   : shadow occupancy and its limits
module tag_fifo_sched
    import tag_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = TAG_DW,
    parameter int ADDR_WIDTH = TAG_AW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          rd_req_i,
    output logic                          rd_gnt_o,
    output logic                          rd_valid_o,
    output logic                          fifo_wr_cs_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic                          fifo_rd_cs_o,
    output logic                          fifo_rd_en_o,
    output logic [ADDR_WIDTH-1:0]         occupancy_o,
    output logic                          full_o,
    output logic                          empty_o
);
    // Capacity is 2**ADDR_WIDTH-1, i.e. all ones in the occupancy register.
    localparam logic [ADDR_WIDTH-1:0] FULL_OCC = '1;

    logic                  wr_go, rd_go, wr_q, rd_q, rv_q;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [DATA_WIDTH-1:0] sel, data_q, data_d;
    logic [ADDR_WIDTH-1:0] occ_q, occ_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .advance_i (wr_go),
        .gnt_o     (arb_gnt)
    );

    // Grants use the pre-update occupancy, so counting on the grant edge can never overrun.
    always_comb begin
        wr_go = |req_i && occ_q != FULL_OCC;
        rd_go = rd_req_i && occ_q != '0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) if (arb_gnt[k]) sel = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        data_d = wr_go ? sel : data_q;
        occ_d  = occ_q + ADDR_WIDTH'(wr_go) - ADDR_WIDTH'(rd_go);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            rv_q   <= 1'b0;
            data_q <= '0;
            occ_q  <= '0;
        end else begin
            wr_q   <= wr_go;
            rd_q   <= rd_go;
            rv_q   <= rd_q;
            data_q <= data_d;
            occ_q  <= occ_d;
        end
    end

    assign gnt_o        = wr_go ? arb_gnt : '0;
    assign rd_gnt_o     = rd_go;
    assign rd_valid_o   = rv_q;
    assign fifo_wr_cs_o = wr_q;
    assign fifo_wr_en_o = wr_q;
    assign fifo_data_o  = data_q;
    assign fifo_rd_cs_o = rd_q;
    assign fifo_rd_en_o = rd_q;
    assign occupancy_o  = occ_q;
    assign full_o       = occ_q == FULL_OCC;
    assign empty_o      = occ_q == '0;

    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        !(wr_go && !rd_go && occ_q == FULL_OCC) && !(rd_go && !wr_go && occ_q == '0));
endmodule
